// File: rtl/wdt.sv
// wdt: bus-slave watchdog timer on a req/ready slave port.
// A first timeout raises an interrupt; a second consecutive timeout emits a
// fixed-length reset request. Kicks are keyed; CTRL/LOAD can be locked.
module wdt #(
  parameter int unsigned RST_CYCLES = 16,
  parameter logic [31:0] KICK_KEY   = 32'h5A5A_A5A5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ready_o,
  output logic        int_o,
  output logic        wdt_rst_o
);

  localparam int unsigned PW = $clog2(RST_CYCLES + 1);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_LOAD   = 3'd1;
  localparam logic [2:0] OFF_COUNT  = 3'd2;
  localparam logic [2:0] OFF_KICK   = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  typedef enum logic {BUS_IDLE, BUS_ACK}   bus_state_e;
  typedef enum logic {RST_IDLE, RST_PULSE} rst_state_e;

  bus_state_e    bus_q, bus_d;
  rst_state_e    rst_q, rst_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          en_q, en_d;
  logic          int_en_q, int_en_d;
  logic          lock_q, lock_d;
  logic [31:0]   load_q, load_d;
  logic [31:0]   count_q, count_d;
  logic          pend_q, pend_d;
  logic          cause_q, cause_d;
  logic          bad_q, bad_d;
  logic          stage_q, stage_d;
  logic [31:0]   data_q, data_d;
  logic          int_q, int_d;
  logic          wrst_q, wrst_d;

  logic        acc, wr, rd;
  logic [2:0]  off;
  logic        wr_ctrl, wr_load, kick_ok, kick_bad;
  logic [2:0]  w1c;
  logic        pulse, en_wr, run, expire, expire0, expire1, reload;
  logic [31:0] rdata;

  // Only address bits [4:2] select a register.
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:5], addr_i[1:0]};

  // Access decode and qualification of the expiry event.
  // A CTRL write that clears en, or a valid kick, suppresses expiry that cycle.
  always_comb begin
    acc      = (bus_q == BUS_IDLE) && req_i;
    wr       = acc && we_i;
    rd       = acc && !we_i;
    off      = addr_i[4:2];
    wr_ctrl  = wr && (off == OFF_CTRL) && !lock_q;
    wr_load  = wr && (off == OFF_LOAD) && !lock_q;
    kick_ok  = wr && (off == OFF_KICK) && (data_i == KICK_KEY);
    kick_bad = wr && (off == OFF_KICK) && (data_i != KICK_KEY);
    w1c      = (wr && (off == OFF_STATUS)) ? data_i[2:0] : '0;
    pulse    = (rst_q == RST_PULSE);
    en_wr    = wr_ctrl ? data_i[0] : en_q;
    run      = en_q && en_wr && !pulse;
    expire   = run && (count_q == '0) && !kick_ok;
    expire0  = expire && !stage_q;
    expire1  = expire && stage_q;
    reload   = kick_ok || (!en_q && en_wr) || expire;
  end

  // Read mux; COUNT returns the value held at the access edge.
  always_comb begin
    rdata = '0;
    case (off)
      OFF_CTRL:   rdata = {29'd0, lock_q, int_en_q, en_q};
      OFF_LOAD:   rdata = load_q;
      OFF_COUNT:  rdata = count_q;
      OFF_STATUS: rdata = {28'd0, stage_q, bad_q, cause_q, pend_q};
      default:    rdata = '0;
    endcase
  end

  // Bus handshake: one ACK cycle per accepted request, req ignored during ACK.
  always_comb begin
    bus_d  = bus_q;
    data_d = data_q;
    case (bus_q)
      BUS_IDLE: if (acc) bus_d = BUS_ACK;
      BUS_ACK:  bus_d = BUS_IDLE;
      default:  bus_d = BUS_IDLE;
    endcase
    if (rd) data_d = rdata;
  end

  // Register file, down-counter and expiry actions.
  // Set terms are ORed after W1C so a coincident expiry keeps its flag.
  always_comb begin
    en_d     = en_wr && !expire1;
    int_en_d = wr_ctrl ? data_i[1] : int_en_q;
    lock_d   = wr_ctrl ? data_i[2] : lock_q;
    load_d   = wr_load ? ((data_i == '0) ? 32'd1 : data_i) : load_q;
    if (reload)   count_d = load_q;
    else if (run) count_d = count_q - 32'd1;
    else          count_d = count_q;
    if (expire0)     stage_d = 1'b1;
    else if (reload) stage_d = 1'b0;
    else             stage_d = stage_q;
    pend_d   = (pend_q  && !w1c[0]) || expire0;
    cause_d  = (cause_q && !w1c[1]) || expire1;
    bad_d    = (bad_q   && !w1c[2]) || kick_bad;
    int_d    = pend_d && int_en_d;
  end

  // Reset-request pulse: output registered one cycle behind the PULSE state.
  always_comb begin
    rst_d  = rst_q;
    pcnt_d = pcnt_q;
    wrst_d = 1'b0;
    case (rst_q)
      RST_IDLE: begin
        if (expire1) begin
          rst_d  = RST_PULSE;
          pcnt_d = PW'(RST_CYCLES);
        end
      end
      RST_PULSE: begin
        wrst_d = 1'b1;
        pcnt_d = pcnt_q - PW'(1);
        if (pcnt_q == PW'(1)) rst_d = RST_IDLE;
      end
      default: rst_d = RST_IDLE;
    endcase
  end

  // State registers; rst_i is the only clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus_q    <= BUS_IDLE;
      rst_q    <= RST_IDLE;
      pcnt_q   <= '0;
      en_q     <= 1'b0;
      int_en_q <= 1'b0;
      lock_q   <= 1'b0;
      load_q   <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      cause_q  <= 1'b0;
      bad_q    <= 1'b0;
      stage_q  <= 1'b0;
      data_q   <= '0;
      int_q    <= 1'b0;
      wrst_q   <= 1'b0;
    end else begin
      bus_q    <= bus_d;
      rst_q    <= rst_d;
      pcnt_q   <= pcnt_d;
      en_q     <= en_d;
      int_en_q <= int_en_d;
      lock_q   <= lock_d;
      load_q   <= load_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      cause_q  <= cause_d;
      bad_q    <= bad_d;
      stage_q  <= stage_d;
      data_q   <= data_d;
      int_q    <= int_d;
      wrst_q   <= wrst_d;
    end
  end

  assign data_o    = data_q;
  assign ready_o   = (bus_q == BUS_ACK);
  assign int_o     = int_q;
  assign wdt_rst_o = wrst_q;

endmodule

// File: tb/tb_wdt.sv
// tb_wdt: scenario tasks for the watchdog plus a randomized bus phase
// checked against a cycle model written from the register/timing rules.
module tb_wdt;

  localparam int          RC  = 16;
  localparam logic [31:0] KEY = 32'h5A5A_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] data_o;
  logic        ready_o, int_o, wdt_rst_o;

  int checks = 0;
  int failures = 0;

  wdt #(.RST_CYCLES(RC), .KICK_KEY(KEY)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .data_i(wdata), .data_o(data_o), .ready_o(ready_o), .int_o(int_o),
    .wdt_rst_o(wdt_rst_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          cyc = 0;
  int          p_start = -1000;
  logic        m_en = 0, m_ie = 0, m_lock = 0, m_pend = 0, m_cause = 0, m_bad = 0, m_stage = 0;
  logic        m_ack = 0, m_int = 0, m_rst = 0;
  logic [31:0] m_load = 0, m_count = 0, m_rdata = 0;

  task automatic model_edge();
    logic        acc, wr, pulse, en_n, ie_n, lock_n, kicked;
    logic [2:0]  off, clr;
    logic [31:0] rd, old_load, load_n;
    pulse = (cyc > p_start) && (cyc <= p_start + RC);
    acc = req && !m_ack;
    wr = acc && we;
    off = addr[4:2];
    case (off)
      3'd0: rd = {29'd0, m_lock, m_ie, m_en};
      3'd1: rd = m_load;
      3'd2: rd = m_count;
      3'd4: rd = {28'd0, m_stage, m_bad, m_cause, m_pend};
      default: rd = 32'd0;
    endcase
    if (acc && !we) m_rdata = rd;
    m_ack = acc;
    en_n = m_en; ie_n = m_ie; lock_n = m_lock;
    old_load = m_load; load_n = m_load;
    if (wr && off == 3'd0 && !m_lock) begin
      en_n = wdata[0]; ie_n = wdata[1]; lock_n = wdata[2];
    end
    if (wr && off == 3'd1 && !m_lock) load_n = (wdata == 0) ? 32'd1 : wdata;
    clr = (wr && off == 3'd4) ? wdata[2:0] : 3'b000;
    if (clr[0]) m_pend = 1'b0;
    if (clr[1]) m_cause = 1'b0;
    if (clr[2]) m_bad = 1'b0;
    kicked = 1'b0;
    if (wr && off == 3'd3) begin
      if (wdata == KEY) begin m_count = old_load; m_stage = 1'b0; kicked = 1'b1; end
      else m_bad = 1'b1;
    end
    if (!kicked) begin
      if (!m_en && en_n) begin
        m_count = old_load; m_stage = 1'b0;
      end else if (m_en && en_n && !pulse) begin
        if (m_count == 0) begin
          m_count = old_load;
          if (!m_stage) begin m_pend = 1'b1; m_stage = 1'b1; end
          else begin m_stage = 1'b0; m_cause = 1'b1; en_n = 1'b0; p_start = cyc; end
        end else m_count = m_count - 1;
      end
    end
    m_en = en_n; m_ie = ie_n; m_lock = lock_n; m_load = load_n;
    m_int = m_pend && m_ie;
    m_rst = pulse;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_en = 0; m_ie = 0; m_lock = 0; m_pend = 0; m_cause = 0; m_bad = 0; m_stage = 0;
      m_ack = 0; m_int = 0; m_rst = 0; m_load = 0; m_count = 0; m_rdata = 0;
      p_start = -1000;
    end else begin
      cyc++;
      model_edge();
    end
  end

  // ---------------- stimulus helpers ----------------
  // One access from a negedge: accepted at the next edge, returns one idle cycle later.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic rdy, output logic [31:0] q, output int acc_cyc);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    @(negedge clk);
    rdy = ready_o; q = data_o; acc_cyc = cyc;
    req = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic rdy; logic [31:0] q; int e;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({data_o, ready_o, int_o, wdt_rst_o} !== 35'd0) begin
      failures++;
      $display("FAIL reset_outputs: got data=%h rdy=%b int=%b rst=%b expected all 0", data_o, ready_o, int_o, wdt_rst_o);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus(1'b0, 32'(i * 4), 32'd0, rdy, q, e);
      checks++;
      if (rdy !== 1'b1 || q !== 32'd0) begin
        failures++;
        $display("FAIL reset_reg%0d: got rdy=%b data=%h expected rdy=1 data=0", i, rdy, q);
      end
    end
  endtask

  task automatic test_expiry();
    logic rdy, ei, er; logic [31:0] q; int e, c;
    bus(1'b1, 32'h04, 32'd9, rdy, q, e);
    bus(1'b1, 32'h00, 32'd3, rdy, q, e);
    for (int t = 0; t < 40; t++) begin
      c = cyc;
      ei = (c >= e + 10);
      er = (c >= e + 21) && (c <= e + 36);
      checks++;
      if ({int_o, wdt_rst_o} !== {ei, er}) begin
        failures++;
        $display("FAIL expiry_timing t+%0d: got int=%b rst=%b expected int=%b rst=%b", c - e, int_o, wdt_rst_o, ei, er);
      end
      @(negedge clk);
    end
    bus(1'b1, 32'h10, 32'd1, rdy, q, e);
    checks++;
    if (int_o !== 1'b0) begin failures++; $display("FAIL int_after_clear: got %b expected 0", int_o); end
    bus(1'b0, 32'h10, 32'd0, rdy, q, e);
    checks++;
    if (q !== 32'h2) begin failures++; $display("FAIL status_after_clear: got %h expected 2", q); end
    bus(1'b0, 32'h08, 32'd0, rdy, q, e);
    checks++;
    if (q !== 32'd9) begin failures++; $display("FAIL count_after_pulse: got %0d expected 9", q); end
    bus(1'b0, 32'h00, 32'd0, rdy, q, e);
    checks++;
    if (q !== 32'h2) begin failures++; $display("FAIL ctrl_en_cleared: got %h expected 2", q); end
  endtask

  task automatic test_kick();
    logic rdy; logic [31:0] q; int e;
    bus(1'b1, 32'h00, 32'd3, rdy, q, e);
    for (int i = 0; i < 25; i++) begin
      bus(1'b1, 32'h0C, KEY, rdy, q, e);
      bus(1'b0, 32'h08, 32'd0, rdy, q, e);
      checks++;
      if (rdy !== 1'b1 || q !== 32'd8) begin
        failures++;
        $display("FAIL kick_count it%0d: got rdy=%b count=%0d expected rdy=1 count=8", i, rdy, q);
      end
      for (int j = 0; j < 4; j++) begin
        checks++;
        if ({int_o, wdt_rst_o} !== 2'b00) begin
          failures++;
          $display("FAIL kick_quiet it%0d: got int=%b rst=%b expected 0 0", i, int_o, wdt_rst_o);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_bad_kick();
    logic rdy; logic [31:0] q, c1; int e;
    bus(1'b1, 32'h0C, KEY, rdy, q, e);
    bus(1'b1, 32'h04, 32'd50, rdy, q, e);
    bus(1'b1, 32'h0C, KEY, rdy, q, e);
    bus(1'b1, 32'h0C, 32'h1234_5678, rdy, q, e);
    bus(1'b0, 32'h10, 32'd0, rdy, q, e);
    checks++;
    if (q !== 32'h6) begin failures++; $display("FAIL bad_kick_status: got %h expected 6", q); end
    bus(1'b0, 32'h08, 32'd0, rdy, c1, e);
    checks++;
    if (c1 !== 32'd45) begin failures++; $display("FAIL bad_kick_count1: got %0d expected 45", c1); end
    bus(1'b0, 32'h08, 32'd0, rdy, q, e);
    checks++;
    if (q !== 32'd43) begin failures++; $display("FAIL bad_kick_count2: got %0d expected 43", q); end
    bus(1'b1, 32'h10, 32'h4, rdy, q, e);
    bus(1'b0, 32'h10, 32'd0, rdy, q, e);
    checks++;
    if (q !== 32'h2) begin failures++; $display("FAIL bad_kick_w1c: got %h expected 2", q); end
    bus(1'b1, 32'h00, 32'd0, rdy, q, e);
  endtask

  task automatic test_kick_at_expiry();
    logic rdy; logic [31:0] q; int e, c0, n;
    bus(1'b1, 32'h04, 32'd9, rdy, q, e);
    bus(1'b1, 32'h00, 32'd3, rdy, q, c0);
    n = 0;
    while (cyc < c0 + 19 && n < 40) begin
      checks++;
      if (wdt_rst_o !== 1'b0) begin failures++; $display("FAIL kexp_pre_rst: got %b expected 0", wdt_rst_o); end
      @(negedge clk);
      n++;
    end
    bus(1'b1, 32'h0C, KEY, rdy, q, e);
    checks++;
    if (e !== c0 + 20) begin failures++; $display("FAIL kexp_align: got edge +%0d expected +20", e - c0); end
    bus(1'b0, 32'h08, 32'd0, rdy, q, e);
    checks++;
    if (q !== 32'd8) begin failures++; $display("FAIL kexp_count: got %0d expected 8", q); end
    bus(1'b0, 32'h10, 32'd0, rdy, q, e);
    checks++;
    if (q !== 32'h3) begin failures++; $display("FAIL kexp_status: got %h expected 3", q); end
    n = 0;
    while (cyc < c0 + 35 && n < 40) begin
      checks++;
      if ({int_o, wdt_rst_o} !== 2'b10) begin
        failures++;
        $display("FAIL kexp_no_reset: got int=%b rst=%b expected 1 0", int_o, wdt_rst_o);
      end
      @(negedge clk);
      n++;
    end
    bus(1'b1, 32'h00, 32'd0, rdy, q, e);
    bus(1'b1, 32'h10, 32'h7, rdy, q, e);
  endtask

  task automatic test_random();
    logic rdy, w; logic [31:0] q, d; logic [2:0] off; int e, gap;
    for (int i = 0; i < 250; i++) begin
      off = 3'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      case (off)
        3'd0: d = $urandom & 32'h3;
        3'd1: d = $urandom_range(0, 20);
        3'd3: d = ($urandom_range(0, 3) != 0) ? KEY : $urandom;
        3'd4: d = $urandom & 32'h7;
        default: d = $urandom;
      endcase
      bus(w, {27'd0, off, 2'b00}, d, rdy, q, e);
      checks++;
      if (rdy !== 1'b1 || q !== m_rdata) begin
        failures++;
        $display("FAIL rand_access op%0d off%0d we%b: got rdy=%b data=%h expected rdy=1 data=%h", i, off, w, rdy, q, m_rdata);
      end
      gap = $urandom_range(0, 5);
      for (int j = 0; j < gap; j++) begin
        checks++;
        if ({int_o, wdt_rst_o, ready_o, data_o} !== {m_int, m_rst, m_ack, m_rdata}) begin
          failures++;
          $display("FAIL rand_idle op%0d: got int=%b rst=%b rdy=%b data=%h expected %b %b %b %h",
                   i, int_o, wdt_rst_o, ready_o, data_o, m_int, m_rst, m_ack, m_rdata);
        end
        @(negedge clk);
      end
    end
    bus(1'b1, 32'h00, 32'd0, rdy, q, e);
    repeat (20) @(negedge clk);
  endtask

  task automatic test_lock();
    logic rdy; logic [31:0] q; int e;
    bus(1'b1, 32'h10, 32'h7, rdy, q, e);
    bus(1'b1, 32'h04, 32'd50, rdy, q, e);
    bus(1'b1, 32'h0C, KEY, rdy, q, e);
    bus(1'b1, 32'h00, 32'h5, rdy, q, e);
    checks++;
    if (rdy !== 1'b1) begin failures++; $display("FAIL lock_ack_ctrl5: got %b expected 1", rdy); end
    bus(1'b1, 32'h00, 32'h0, rdy, q, e);
    checks++;
    if (rdy !== 1'b1) begin failures++; $display("FAIL lock_ack_ctrl0: got %b expected 1", rdy); end
    bus(1'b1, 32'h04, 32'd3, rdy, q, e);
    checks++;
    if (rdy !== 1'b1) begin failures++; $display("FAIL lock_ack_load: got %b expected 1", rdy); end
    bus(1'b0, 32'h00, 32'd0, rdy, q, e);
    checks++;
    if (q !== 32'h5) begin failures++; $display("FAIL lock_ctrl_read: got %h expected 5", q); end
    bus(1'b0, 32'h04, 32'd0, rdy, q, e);
    checks++;
    if (q !== 32'd50) begin failures++; $display("FAIL lock_load_read: got %0d expected 50", q); end
  endtask

  task automatic test_rst_mid_pulse();
    logic rdy; logic [31:0] q; int e, n;
    n = 0;
    while (wdt_rst_o !== 1'b1 && n < 200) begin
      checks++;
      if ({int_o, wdt_rst_o, ready_o, data_o} !== {m_int, m_rst, m_ack, m_rdata}) begin
        failures++;
        $display("FAIL lock_run: got int=%b rst=%b rdy=%b data=%h expected %b %b %b %h",
                 int_o, wdt_rst_o, ready_o, data_o, m_int, m_rst, m_ack, m_rdata);
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (wdt_rst_o !== 1'b1) begin failures++; $display("FAIL pulse_wait: got rst=%b expected 1 within 200 cycles", wdt_rst_o); end
    bus(1'b0, 32'h10, 32'd0, rdy, q, e);
    checks++;
    if (rdy !== 1'b1 || q !== m_rdata || q[1] !== 1'b1) begin
      failures++;
      $display("FAIL pulse_bus_read: got rdy=%b data=%h expected rdy=1 data=%h with cause", rdy, q, m_rdata);
    end
    checks++;
    if (wdt_rst_o !== 1'b1) begin failures++; $display("FAIL pulse_still_high: got %b expected 1", wdt_rst_o); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({data_o, ready_o, int_o, wdt_rst_o} !== 35'd0) begin
      failures++;
      $display("FAIL async_reset: got data=%h rdy=%b int=%b rst=%b expected all 0", data_o, ready_o, int_o, wdt_rst_o);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus(1'b0, 32'(i * 4), 32'd0, rdy, q, e);
      checks++;
      if (rdy !== 1'b1 || q !== 32'd0) begin
        failures++;
        $display("FAIL post_reset_reg%0d: got rdy=%b data=%h expected rdy=1 data=0", i, rdy, q);
      end
    end
    checks++;
    if (wdt_rst_o !== 1'b0) begin failures++; $display("FAIL post_reset_rst: got %b expected 0", wdt_rst_o); end
  endtask

  initial begin
    test_reset();
    test_expiry();
    test_kick();
    test_bad_kick();
    test_kick_at_expiry();
    test_random();
    test_lock();
    test_rst_mid_pulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/wdt.md
# wdt

Bus-slave watchdog timer for the tinyriscv SoC. It occupies a free rib slave slot with the same req/ready handshake as the uart and i2c slaves, and drives a reset request back upstream into the SoC reset tree (ANDed into the core/peripheral reset at top level). Firmware must kick it periodically. A first timeout raises an interrupt, and a second consecutive timeout asserts a reset pulse of fixed length.

## Interface
Parameters:
- RST_CYCLES, 16, length of the wdt_rst_o pulse in clk_i cycles (≥1)
- KICK_KEY, 32'h5A5A_A5A5, value that must be written to KICK to reload

Ports:
- clk_i  in  1  system clock; one clock domain.
- rst_i  in  1  asynchronous, active-high reset. This is the only thing that clears the block; wdt_rst_o does not feed it.
- req_i  in  1  bus request; held by the master until ready_o.
- we_i  in  1  write enable, qualified by req_i.
- addr_i  in  32  byte address; only bits [4:2] are decoded.
- data_i  in  32  write data.
- data_o  out  32  read data, valid while ready_o=1.
- ready_o  out  1  one-cycle acknowledge.
- int_o  out  1  level interrupt = STATUS.pend & CTRL.int_en.
- wdt_rst_o  out  1  reset request, active-high.

## Operation
Register map (word offsets):
- 0x00 CTRL (RW): bit0 en, bit1 int_en, bit2 lock.
  - Writing lock=1 makes CTRL and LOAD read-only until rst_i.
  - Once lock is set, en cannot be cleared.
- 0x04 LOAD (RW): reload value. A write of 0 is stored as 1.
- 0x08 COUNT (RO): current down-counter value.
- 0x0C KICK (WO, reads 0):
  - Write KICK_KEY: COUNT←LOAD and stage←0.
  - Any other value is ignored and sets STATUS.bad_kick.
- 0x10 STATUS: bit0 pend (W1C), bit1 rst_cause (W1C), bit2 bad_kick (W1C), bit3 stage (RO).
- Unmapped offsets: reads return 0, writes are ignored, and the access is still acknowledged.

Counter:
- The en 0→1 transition loads COUNT←LOAD and stage←0.
- While en=1 and no reset pulse is active, COUNT decrements by 1 per cycle.
- While en=0, COUNT holds its value.

Expiry handling, evaluated at COUNT==0 with en=1:
- stage=0: pend←1, stage←1, COUNT←LOAD.
- stage=1: start the reset pulse, rst_cause←1, en←0 (even if lock=1), stage←0, COUNT←LOAD.

Reset pulse FSM:
- States: IDLE, PULSE.
- IDLE→PULSE on stage-1 expiry.
- In PULSE, wdt_rst_o=1 for exactly RST_CYCLES cycles, tracked by an internal counter, then the FSM returns to IDLE.
- Register state is retained through the pulse; only rst_i clears it.
- Bus accesses during PULSE are serviced normally.

Priorities when events coincide:
- Valid kick and expiry in the same cycle: the kick wins; no pend set, no reset.
- W1C clear of pend and a new stage-0 expiry in the same cycle: pend ends at 1.
- CTRL write of en=0 and expiry in the same cycle: the write wins; no expiry action.

Reset values:
- All registers 0: en=0, LOAD=0 (reads as 0 until written), COUNT=0, STATUS=0.
- Outputs: data_o=0, ready_o=0, int_o=0, wdt_rst_o=0, FSM=IDLE.

## Timing
Bus FSM has two states, IDLE and ACK.
- IDLE: req_i=1 sampled at edge N → ACK.
- At edge N:
  - A write commits and is visible from cycle N+1.
  - Read data is registered into data_o at the same edge.
- ACK: ready_o=1 for exactly the cycle after edge N, then the FSM returns to IDLE.
  - req_i is ignored during ACK, so back-to-back accesses take 2 cycles each.
  - data_o holds its last value outside ACK.
- Read latency is 1 cycle. A COUNT read returns the value at edge N.

Output timing:
- int_o and wdt_rst_o are registered.
- wdt_rst_o rises the cycle after the expiry edge.

Counter timing:
- Timeout period is LOAD+1 cycles from reload to the expiry action.
- The worst-case interval from the last valid kick to wdt_rst_o is 2·(LOAD+1)+1 cycles.

Reset:
- rst_i asserted mid-pulse or mid-access drops every output to its reset value immediately (asynchronous).
- Deassertion is synchronised externally.

## Test plan
- LOAD=9, CTRL=0x3, no kick:
  - pend=1 and int_o=1 after 10 cycles.
  - wdt_rst_o high for 16 cycles starting 11 cycles later.
  - STATUS reads 0x2 after clearing pend.
- LOAD=9, en, KICK_KEY written every 8 cycles for 200 cycles → int_o=0, wdt_rst_o=0, COUNT never below 2.
- KICK with 0x1234_5678 → bad_kick=1 and COUNT keeps decrementing. W1C 0x4 → bad_kick=0.
- CTRL=0x5 (lock) then write CTRL=0 and LOAD=3 → CTRL reads 0x5 and LOAD is unchanged; each write acked with ready_o one cycle after req_i.
- Valid KICK landing on the COUNT==0 cycle of stage 1 → no wdt_rst_o; COUNT=LOAD next cycle.
- rst_i pulsed 3 cycles into the wdt_rst_o pulse → wdt_rst_o=0 immediately and all registers read 0 afterwards.
